// File: rtl/riscv_mem_arbiter_if.sv
// rtl/riscv_mem_arbiter_if.sv - fetch/data/memory bus bundle for the unified memory arbiter
interface riscv_mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic            i_if_req;
    logic [XLEN-1:0] i_if_addr;
    logic            o_if_valid;
    logic [XLEN-1:0] o_if_rdata;
    logic            o_if_stall;

    logic            i_d_req;
    logic            i_d_wr_en;
    logic [XLEN-1:0] i_d_addr;
    logic [XLEN-1:0] i_d_wdata;
    logic [3:0]      i_d_byte_sel;
    logic            o_d_valid;
    logic [XLEN-1:0] o_d_rdata;
    logic            o_d_stall;

    logic            o_mem_req;
    logic            i_mem_ready;
    logic [XLEN-1:0] o_mem_addr;
    logic            o_mem_wr_en;
    logic [3:0]      o_mem_byte_sel;
    logic [XLEN-1:0] o_mem_wdata;
    logic            i_mem_rvalid;
    logic [XLEN-1:0] i_mem_rdata;
    logic            o_protocol_err;

    // Arbiter side
    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_valid, o_if_rdata, o_if_stall,
        input  i_d_req, i_d_wr_en, i_d_addr, i_d_wdata, i_d_byte_sel,
        output o_d_valid, o_d_rdata, o_d_stall,
        output o_mem_req, o_mem_addr, o_mem_wr_en, o_mem_byte_sel, o_mem_wdata,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
        output o_protocol_err
    );

    // Core and memory side
    modport master (
        output i_if_req, i_if_addr,
        input  o_if_valid, o_if_rdata, o_if_stall,
        output i_d_req, i_d_wr_en, i_d_addr, i_d_wdata, i_d_byte_sel,
        input  o_d_valid, o_d_rdata, o_d_stall,
        input  o_mem_req, o_mem_addr, o_mem_wr_en, o_mem_byte_sel, o_mem_wdata,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata,
        input  o_protocol_err
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - fetch/data arbiter in front of a single-ported unified memory
module riscv_mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    riscv_mem_arbiter_if.slave    bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]      r_state;
    logic            r_owner_d;
    logic [CW-1:0]   r_starve_cnt;
    logic            r_mem_req;
    logic [XLEN-1:0] r_mem_addr;
    logic            r_mem_wr_en;
    logic [3:0]      r_mem_byte_sel;
    logic [XLEN-1:0] r_mem_wdata;
    logic            r_if_valid;
    logic            r_d_valid;
    logic [XLEN-1:0] r_if_rdata;
    logic [XLEN-1:0] r_d_rdata;
    logic            r_protocol_err;

    logic w_if_elig;
    logic w_d_elig;
    logic w_starved;
    logic w_grant_d;
    logic w_grant_if;

    // A port pulsing valid this cycle has just been served and must not be granted again
    assign w_if_elig  = bus.i_if_req & ~r_if_valid;
    assign w_d_elig   = bus.i_d_req & ~r_d_valid;
    assign w_starved  = w_if_elig & (r_starve_cnt == CW'(STARVE_LIMIT));
    assign w_grant_d  = w_d_elig & ~w_starved;
    assign w_grant_if = w_if_elig & ~w_grant_d;

    // Arbitration, memory sequencing and response capture
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state        <= S_IDLE;
            r_owner_d      <= 1'b0;
            r_starve_cnt   <= '0;
            r_mem_req      <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wr_en    <= 1'b0;
            r_mem_byte_sel <= 4'h0;
            r_mem_wdata    <= '0;
            r_if_valid     <= 1'b0;
            r_d_valid      <= 1'b0;
            r_if_rdata     <= '0;
            r_d_rdata      <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_mem_rvalid) begin
                        r_protocol_err <= 1'b1;
                    end
                    if (w_grant_d) begin
                        r_owner_d      <= 1'b1;
                        r_mem_req      <= 1'b1;
                        r_mem_addr     <= bus.i_d_addr;
                        r_mem_wr_en    <= bus.i_d_wr_en;
                        r_mem_byte_sel <= bus.i_d_byte_sel;
                        r_mem_wdata    <= bus.i_d_wdata;
                        r_state        <= S_ISSUE;
                        if (!w_if_elig) begin
                            r_starve_cnt <= '0;
                        end else if (r_starve_cnt != CW'(STARVE_LIMIT)) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end else if (w_grant_if) begin
                        r_owner_d      <= 1'b0;
                        r_mem_req      <= 1'b1;
                        r_mem_addr     <= bus.i_if_addr;
                        r_mem_wr_en    <= 1'b0;
                        r_mem_byte_sel <= 4'hF;
                        r_mem_wdata    <= '0;
                        r_starve_cnt   <= '0;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.i_mem_rvalid) begin
                        r_protocol_err <= 1'b1;
                    end
                    if (bus.i_mem_ready) begin
                        r_mem_req <= 1'b0;
                        if (r_mem_wr_en) begin
                            r_d_valid <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.i_mem_rvalid) begin
                        if (r_owner_d) begin
                            r_d_rdata <= bus.i_mem_rdata;
                            r_d_valid <= 1'b1;
                        end else begin
                            r_if_rdata <= bus.i_mem_rdata;
                            r_if_valid <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_if_valid     = r_if_valid;
    assign bus.o_if_rdata     = r_if_rdata;
    assign bus.o_d_valid      = r_d_valid;
    assign bus.o_d_rdata      = r_d_rdata;
    assign bus.o_mem_req      = r_mem_req;
    assign bus.o_mem_addr     = r_mem_addr;
    assign bus.o_mem_wr_en    = r_mem_wr_en;
    assign bus.o_mem_byte_sel = r_mem_byte_sel;
    assign bus.o_mem_wdata    = r_mem_wdata;
    assign bus.o_protocol_err = r_protocol_err;

    // Stalls follow the request combinationally so the hazard unit sees them in the request cycle
    assign bus.o_if_stall = i_rstn & bus.i_if_req & ~r_if_valid;
    assign bus.o_d_stall  = i_rstn & bus.i_d_req & ~r_d_valid;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - bench for riscv_mem_arbiter
module tb_riscv_mem_arbiter;
    localparam int XLEN         = 32;
    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rstn;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    riscv_mem_arbiter_if #(.XLEN(XLEN)) bus ();

    riscv_mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    // Reference model state: requesters, memory contents, outstanding transaction
    logic [31:0] ref_mem [16];
    logic        m_if_pend, m_d_pend, m_d_wr;
    logic [31:0] m_if_addr, m_d_addr, m_d_wdata;
    logic [3:0]  m_d_sel;
    logic        m_issuing, m_waiting, m_own_d, m_wr;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_sel;
    logic        m_exp_if_v, m_exp_d_v;
    logic [31:0] m_exp_if_rd, m_exp_d_rd;
    int          m_rv_delay, m_overtakes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.i_if_req = 0; bus.i_if_addr = 0;
        bus.i_d_req = 0; bus.i_d_wr_en = 0; bus.i_d_addr = 0; bus.i_d_wdata = 0; bus.i_d_byte_sel = 0;
        bus.i_mem_ready = 0; bus.i_mem_rvalid = 0; bus.i_mem_rdata = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_if_valid"}, bus.o_if_valid, 0);
        chk({tag, "_if_rdata"}, bus.o_if_rdata, 0);
        chk({tag, "_if_stall"}, bus.o_if_stall, 0);
        chk({tag, "_d_valid"}, bus.o_d_valid, 0);
        chk({tag, "_d_rdata"}, bus.o_d_rdata, 0);
        chk({tag, "_d_stall"}, bus.o_d_stall, 0);
        chk({tag, "_mem_req"}, bus.o_mem_req, 0);
        chk({tag, "_mem_addr"}, bus.o_mem_addr, 0);
        chk({tag, "_mem_wr_en"}, bus.o_mem_wr_en, 0);
        chk({tag, "_mem_sel"}, 32'(bus.o_mem_byte_sel), 0);
        chk({tag, "_mem_wdata"}, bus.o_mem_wdata, 0);
        chk({tag, "_perr"}, bus.o_protocol_err, 0);
    endtask

    // One cycle of randomized traffic: check what the model predicted, then plan the next edge
    task automatic rand_step();
        logic if_elig, d_elig, nx_if_v, nx_d_v, rdy;
        chk("rnd_if_valid", bus.o_if_valid, m_exp_if_v);
        chk("rnd_d_valid", bus.o_d_valid, m_exp_d_v);
        chk("rnd_if_rdata", bus.o_if_rdata, m_exp_if_rd);
        chk("rnd_d_rdata", bus.o_d_rdata, m_exp_d_rd);
        chk("rnd_if_stall", bus.o_if_stall, m_if_pend & ~m_exp_if_v);
        chk("rnd_d_stall", bus.o_d_stall, m_d_pend & ~m_exp_d_v);
        chk("rnd_mem_req", bus.o_mem_req, m_issuing);
        if (m_issuing) begin
            chk("rnd_mem_addr", bus.o_mem_addr, m_addr);
            chk("rnd_mem_wr_en", bus.o_mem_wr_en, m_wr);
            chk("rnd_mem_sel", 32'(bus.o_mem_byte_sel), 32'(m_sel));
            chk("rnd_mem_wdata", bus.o_mem_wdata, m_wdata);
        end
        chk("rnd_perr", bus.o_protocol_err, 0);

        if (m_exp_if_v) m_if_pend = 0;
        if (m_exp_d_v)  m_d_pend  = 0;
        if (!m_if_pend && $urandom_range(0, 3) != 0) begin
            m_if_pend = 1;
            m_if_addr = (32'($urandom) & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
        end
        if (!m_d_pend && $urandom_range(0, 3) != 0) begin
            m_d_pend  = 1;
            m_d_wr    = 1'($urandom_range(0, 1));
            m_d_addr  = (32'($urandom) & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
            m_d_wdata = $urandom;
            m_d_sel   = 4'($urandom_range(0, 15));
        end

        nx_if_v = 0;
        nx_d_v  = 0;
        rdy     = 1'($urandom_range(0, 1));
        bus.i_mem_rvalid = 0;
        bus.i_mem_rdata  = $urandom;
        if (m_waiting) begin
            if (m_rv_delay == 0) begin
                bus.i_mem_rvalid = 1;
                bus.i_mem_rdata  = ref_mem[m_addr[5:2]];
                if (m_own_d) begin
                    nx_d_v = 1; m_exp_d_rd = ref_mem[m_addr[5:2]];
                end else begin
                    nx_if_v = 1; m_exp_if_rd = ref_mem[m_addr[5:2]];
                end
                m_waiting = 0;
            end else begin
                m_rv_delay--;
            end
        end else if (m_issuing) begin
            if (rdy) begin
                m_issuing = 0;
                if (m_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (m_sel[b]) ref_mem[m_addr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
                    nx_d_v = 1;
                end else begin
                    m_waiting  = 1;
                    m_rv_delay = $urandom_range(0, 2);
                end
            end
        end else begin
            if_elig = m_if_pend & ~m_exp_if_v;
            d_elig  = m_d_pend & ~m_exp_d_v;
            if (d_elig && !(if_elig && m_overtakes == STARVE_LIMIT)) begin
                m_issuing = 1; m_own_d = 1;
                m_addr = m_d_addr; m_wr = m_d_wr; m_sel = m_d_sel; m_wdata = m_d_wdata;
                m_overtakes = if_elig ? ((m_overtakes < STARVE_LIMIT) ? m_overtakes + 1 : m_overtakes) : 0;
            end else if (if_elig) begin
                m_issuing = 1; m_own_d = 0;
                m_addr = m_if_addr; m_wr = 0; m_sel = 4'hF; m_wdata = 0;
                m_overtakes = 0;
            end
        end

        bus.i_mem_ready  = rdy;
        bus.i_if_req     = m_if_pend;
        bus.i_if_addr    = m_if_addr;
        bus.i_d_req      = m_d_pend;
        bus.i_d_wr_en    = m_d_wr;
        bus.i_d_addr     = m_d_addr;
        bus.i_d_wdata    = m_d_wdata;
        bus.i_d_byte_sel = m_d_sel;
        m_exp_if_v = nx_if_v;
        m_exp_d_v  = nx_d_v;
        @(negedge clk);
    endtask

    initial begin
        // Reset: every output low, stalls forced low even with requests up
        rstn = 0;
        clear_inputs();
        bus.i_if_req = 1; bus.i_d_req = 1;
        repeat (2) @(negedge clk);
        #1 chk_zero("reset");
        clear_inputs();
        @(negedge clk);
        rstn = 1;

        // Fetch only, minimum latency
        bus.i_if_req = 1; bus.i_if_addr = 32'h100;
        #1 chk("fetch_stall_t0", bus.o_if_stall, 1);
        @(negedge clk);
        chk("fetch_mem_req", bus.o_mem_req, 1);
        chk("fetch_mem_addr", bus.o_mem_addr, 32'h100);
        chk("fetch_mem_sel", 32'(bus.o_mem_byte_sel), 32'hF);
        chk("fetch_mem_wr_en", bus.o_mem_wr_en, 0);
        chk("fetch_stall_t1", bus.o_if_stall, 1);
        bus.i_mem_ready = 1;
        @(negedge clk);
        chk("fetch_req_drop", bus.o_mem_req, 0);
        chk("fetch_valid_t2", bus.o_if_valid, 0);
        chk("fetch_stall_t2", bus.o_if_stall, 1);
        bus.i_mem_ready = 0; bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'h0050_0093;
        @(negedge clk);
        chk("fetch_valid_t3", bus.o_if_valid, 1);
        chk("fetch_rdata", bus.o_if_rdata, 32'h0050_0093);
        chk("fetch_stall_t3", bus.o_if_stall, 0);
        chk("fetch_no_d_valid", bus.o_d_valid, 0);
        bus.i_mem_rvalid = 0; bus.i_if_req = 0;
        @(negedge clk);
        chk("fetch_valid_t4", bus.o_if_valid, 0);
        chk("fetch_rdata_hold", bus.o_if_rdata, 32'h0050_0093);

        // Store with ready held low for three cycles
        bus.i_d_req = 1; bus.i_d_wr_en = 1; bus.i_d_addr = 32'h2000;
        bus.i_d_wdata = 32'hDEAD_BEEF; bus.i_d_byte_sel = 4'b0011;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("store_mem_req", bus.o_mem_req, 1);
            chk("store_mem_addr", bus.o_mem_addr, 32'h2000);
            chk("store_mem_wdata", bus.o_mem_wdata, 32'hDEAD_BEEF);
            chk("store_mem_sel", 32'(bus.o_mem_byte_sel), 32'h3);
            chk("store_mem_wr_en", bus.o_mem_wr_en, 1);
            chk("store_d_valid_early", bus.o_d_valid, 0);
            if (k == 3) bus.i_mem_ready = 1;
            @(negedge clk);
        end
        chk("store_d_valid", bus.o_d_valid, 1);
        chk("store_req_drop", bus.o_mem_req, 0);
        chk("store_d_rdata", bus.o_d_rdata, 0);
        chk("store_d_stall", bus.o_d_stall, 0);
        bus.i_d_req = 0; bus.i_mem_ready = 0;
        @(negedge clk);
        chk("store_d_valid_end", bus.o_d_valid, 0);
        chk("store_no_regrant", bus.o_mem_req, 0);

        // Unexpected rvalid while idle
        bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.i_mem_rvalid = 0;
        chk("perr_set", bus.o_protocol_err, 1);
        chk("perr_no_if_valid", bus.o_if_valid, 0);
        chk("perr_no_d_valid", bus.o_d_valid, 0);
        repeat (3) @(negedge clk);
        chk("perr_sticky", bus.o_protocol_err, 1);
        chk("perr_if_rdata", bus.o_if_rdata, 32'h0050_0093);
        rstn = 0;
        #1 chk("perr_cleared", bus.o_protocol_err, 0);
        @(negedge clk);
        rstn = 1;

        // Reset while a load waits for data
        bus.i_d_req = 1; bus.i_d_wr_en = 0; bus.i_d_addr = 32'h40; bus.i_d_byte_sel = 4'hF;
        @(negedge clk);
        chk("rw_issue", bus.o_mem_req, 1);
        bus.i_mem_ready = 1;
        @(negedge clk);
        bus.i_mem_ready = 0;
        chk("rw_wait_req", bus.o_mem_req, 0);
        chk("rw_wait_valid", bus.o_d_valid, 0);
        rstn = 0;
        #1 chk_zero("rst_wait");
        clear_inputs();
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        chk("rw_idle_req", bus.o_mem_req, 0);
        bus.i_if_req = 1; bus.i_if_addr = 32'h200;
        @(negedge clk);
        chk("rw_fetch_req", bus.o_mem_req, 1);
        chk("rw_fetch_addr", bus.o_mem_addr, 32'h200);
        bus.i_mem_ready = 1;
        @(negedge clk);
        bus.i_mem_ready = 0; bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'h1234_5678;
        @(negedge clk);
        bus.i_mem_rvalid = 0; bus.i_if_req = 0;
        chk("rw_fetch_valid", bus.o_if_valid, 1);
        chk("rw_fetch_rdata", bus.o_if_rdata, 32'h1234_5678);
        chk("rw_fetch_perr", bus.o_protocol_err, 0);
        chk("rw_d_rdata", bus.o_d_rdata, 0);
        bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        bus.i_mem_rvalid = 0;
        chk("rw_late_perr", bus.o_protocol_err, 1);
        chk("rw_late_if_valid", bus.o_if_valid, 0);
        chk("rw_late_d_valid", bus.o_d_valid, 0);

        // Randomized traffic against the reference model
        rstn = 0;
        clear_inputs();
        @(negedge clk);
        rstn = 1;
        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        m_if_pend = 0; m_d_pend = 0; m_d_wr = 0;
        m_if_addr = 0; m_d_addr = 0; m_d_wdata = 0; m_d_sel = 0;
        m_issuing = 0; m_waiting = 0; m_own_d = 0; m_wr = 0;
        m_addr = 0; m_wdata = 0; m_sel = 0;
        m_exp_if_v = 0; m_exp_d_v = 0; m_exp_if_rd = 0; m_exp_d_rd = 0;
        m_rv_delay = 0; m_overtakes = 0;
        for (int c = 0; c < 3000; c++) rand_step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one single-ported unified memory between the pipelined core's instruction-fetch port and data (load/store) port.
- Arbitrates between the two ports and sequences each transaction as issue, then accept, then (for reads) response.
- Drives stall requests back toward the hazard unit.
- Data port has priority, with a starvation guard for fetch; one transaction outstanding at a time.

Parameters:
- XLEN, 32, data/address width
- STARVE_LIMIT, 4, max consecutive data grants while fetch is waiting; must be ≥1

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_if_req  in  1  fetch request; held until o_if_valid
- i_if_addr  in  XLEN  fetch address
- o_if_valid  out  1  one-cycle pulse: o_if_rdata valid, request consumed
- o_if_rdata  out  XLEN  fetched instruction
- o_if_stall  out  1  fetch waiting
- i_d_req  in  1  data request; held until o_d_valid
- i_d_wr_en  in  1  1=store, 0=load
- i_d_addr  in  XLEN  data address
- i_d_wdata  in  XLEN  store data
- i_d_byte_sel  in  4  byte enables
- o_d_valid  out  1  one-cycle pulse: load data valid / store done
- o_d_rdata  out  XLEN  load data
- o_d_stall  out  1  data waiting
- o_mem_req  out  1  memory request
- i_mem_ready  in  1  memory accepts request when high with o_mem_req
- o_mem_addr  out  XLEN  memory address
- o_mem_wr_en  out  1  memory write enable
- o_mem_byte_sel  out  4  memory byte enables
- o_mem_wdata  out  XLEN  memory write data
- i_mem_rvalid  in  1  read data valid
- i_mem_rdata  in  XLEN  read data
- o_protocol_err  out  1  sticky: unexpected i_mem_rvalid

Behaviour:
- Reset (async, i_rstn=0):
  - state=IDLE, starvation counter=0.
  - All outputs 0, including rdata registers and o_protocol_err.
  - Any in-flight transaction is abandoned.
- All outputs are registered except the stalls:
  - o_if_stall = i_if_req & ~o_if_valid
  - o_d_stall = i_d_req & ~o_d_valid
  - Both are forced 0 while i_rstn=0.
- Requesters must hold req and all fields stable until their valid pulse.
- IDLE:
  - Eligible ports: if_req & ~o_if_valid; d_req & ~o_d_valid. A port whose valid is high this cycle is already consumed and is not re-granted.
  - Only one eligible: grant it.
  - Both eligible: grant data, unless counter==STARVE_LIMIT, then grant fetch.
  - On grant, latch addr/wr_en/byte_sel/wdata into memory-side registers. Fetch always uses wr_en=0, byte_sel=4'b1111, wdata=0.
  - Record the granted owner; go to ISSUE.
- Starvation counter, updated at grant:
  - Data grant while fetch eligible: +1, saturating at STARVE_LIMIT.
  - Data grant with fetch not eligible: 0.
  - Fetch grant: 0.
- ISSUE:
  - o_mem_req=1 with the latched fields, held stable until i_mem_ready.
  - On accept, o_mem_req drops next cycle.
  - Write accept: o_d_valid pulses the next cycle; go to IDLE.
  - Read accept: go to WAIT.
- WAIT:
  - o_mem_req=0. i_mem_rvalid never coincides with the accept cycle; minimum is 1 cycle after accept.
  - On i_mem_rvalid: capture i_mem_rdata into the owner's rdata register and pulse the owner's valid the next cycle; go to IDLE.
  - The non-owner's rdata is unchanged.
  - No timeout; WAIT persists until rvalid.
- o_protocol_err: i_mem_rvalid in IDLE or ISSUE sets it (sticky until reset); data is ignored and state is unchanged.
- Minimum latency, with ready=1 and rvalid 1 cycle after accept:
  - Read: req at T0 (IDLE) → ISSUE T1 → WAIT T2 (rvalid) → valid at T3.
  - Write: valid at T2.
- The rdata registers hold their value after the valid pulse until the next capture for that port.
- Reset during ISSUE/WAIT: return to IDLE and drop o_mem_req immediately. The memory side must not see a stale request afterward.

Test Plan:
- Fetch only: if_req=1 addr=0x100, ready=1, rvalid+rdata=0x00500093 one cycle after accept → o_mem_addr=0x100, byte_sel=4'hF, wr_en=0; o_if_valid pulse at T3 with rdata 0x00500093; o_if_stall 1 for T0–T2, 0 at T3.
- Store: d_req, wr_en=1, addr=0x2000, wdata=0xDEADBEEF, sel=4'b0011, ready held low 3 cycles → o_mem_req held with stable fields for 4 cycles; o_d_valid 1 cycle after accept; no o_d_rdata change.
- Both requests at T0 → data granted first; fetch granted in the following IDLE; if_valid follows d_valid; each valid lasts exactly 1 cycle and no port is double-granted.
- Starvation with STARVE_LIMIT=4: fetch held, data re-requests every IDLE → grants in order D,D,D,D,F,D…; counter resets after F.
- rvalid pulse while IDLE → o_protocol_err=1 and stays 1, no valid pulses; clears only on reset.
- Reset asserted in WAIT with a load outstanding → all outputs 0 immediately; after release, a new fetch completes normally and the late rvalid arriving in IDLE sets o_protocol_err.
